// File: rtl/sdram_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller: whole-cycle grants, round-robin.
// Optional grant counters on stat0_o/stat1_o when SDRAM_ARB_STATS_EN is defined.
module sdram_arbiter #(
  parameter int AWIDTH = 25,
  parameter int DWIDTH = 32,
  parameter int SELW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AWIDTH-1:0] m0_adr_i,
  input  logic [DWIDTH-1:0] m0_dat_i,
  input  logic [SELW-1:0]   m0_sel_i,
  output logic [DWIDTH-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_stall_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AWIDTH-1:0] m1_adr_i,
  input  logic [DWIDTH-1:0] m1_dat_i,
  input  logic [SELW-1:0]   m1_sel_i,
  output logic [DWIDTH-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_stall_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AWIDTH-1:0] s_adr_o,
  output logic [DWIDTH-1:0] s_dat_o,
  output logic [SELW-1:0]   s_sel_o,
  input  logic [DWIDTH-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_stall_i,
  output logic [31:0]       stat0_o,
  output logic [31:0]       stat1_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   g0, g1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_d = GNT0;
        else if (m1_cyc_i)        state_d = GNT1;
      end
      GNT0: begin
        // release only when the master ends its bus cycle; hand straight over if the other waits
        if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign g0 = (state_q == GNT0);
  assign g1 = (state_q == GNT1);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (g0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
    end else if (g1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
    end
  end

  // gating ack with the master's own cyc drops late acks from an abandoned cycle
  assign m0_ack_o   = s_ack_i & g0 & m0_cyc_i;
  assign m1_ack_o   = s_ack_i & g1 & m1_cyc_i;
  assign m0_dat_o   = g0 ? s_dat_i : '0;
  assign m1_dat_o   = g1 ? s_dat_i : '0;
  assign m0_stall_o = g0 ? s_stall_i : 1'b1;
  assign m1_stall_o = g1 ? s_stall_i : 1'b1;

`ifdef SDRAM_ARB_STATS_EN
  logic [31:0] stat0_q, stat1_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stat0_q <= '0;
      stat1_q <= '0;
    end else begin
      if (state_d == GNT0 && state_q != GNT0) stat0_q <= stat0_q + 32'd1;
      if (state_d == GNT1 && state_q != GNT1) stat1_q <= stat1_q + 32'd1;
    end
  end

  assign stat0_o = stat0_q;
  assign stat1_o = stat1_q;
`else
  assign stat0_o = '0;
  assign stat1_o = '0;
`endif

endmodule
